// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: opcodes, FSM states, request/response
// records and the response-shaping rule applied when a result is captured.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_DIV = 4'd3;

    localparam int unsigned SEQ_TAG_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StCapt,
        StResp
    } seq_state_e;

    typedef struct packed {
        logic [7:0]           a;
        logic [7:0]           b;
        logic [3:0]           sel;
        logic [SEQ_TAG_W-1:0] tag;
    } alu_req_t;

    typedef struct packed {
        logic [7:0]           data;
        logic                 carry;
        logic                 err;
        logic [SEQ_TAG_W-1:0] tag;
    } alu_rsp_t;

    // Carry is only meaningful for add; divide-by-zero replaces the ALU result.
    function automatic alu_rsp_t make_rsp(input logic [3:0]           sel,
                                          input logic [7:0]           b,
                                          input logic [7:0]           out,
                                          input logic                 carry,
                                          input logic [SEQ_TAG_W-1:0] tag);
        alu_rsp_t r;
        r.data  = out;
        r.carry = 1'b0;
        r.err   = 1'b0;
        r.tag   = tag;
        case (sel)
            OP_ADD: r.carry = carry;
            OP_SUB, OP_MUL: ;
            OP_DIV: begin
                if (b == 8'd0) begin
                    r.data = 8'hFF;
                    r.err  = 1'b1;
                end
            end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous request FIFO with occupancy count. The caller never pushes when full
// nor pops when empty.
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  alu_req_t               wdata_i,
    output alu_req_t               rdata_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]   count_q;
    alu_req_t        mem_q [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the registered 8-bit ALU: buffers requests, issues one at a
// time, and returns tagged, error-checked responses in request order.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = SEQ_TAG_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [7:0]             cmd_a_i,
    input  logic [7:0]             cmd_b_i,
    input  logic [3:0]             cmd_sel_i,
    input  logic [TAG_W-1:0]       cmd_tag_i,
    output logic [7:0]             alu_a_o,
    output logic [7:0]             alu_b_o,
    output logic [3:0]             alu_sel_o,
    input  logic [7:0]             alu_out_i,
    input  logic                   alu_carry_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [7:0]             rsp_data_o,
    output logic                   rsp_carry_o,
    output logic                   rsp_err_o,
    output logic [TAG_W-1:0]       rsp_tag_o,
    output logic [$clog2(DEPTH):0] fifo_count_o
);

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [CntW-1:0] count;
    logic            push, pop, fifo_empty;
    alu_req_t        push_req, head;

    seq_state_e           state_q;
    logic [7:0]           alu_a_q, alu_b_q;
    logic [3:0]           alu_sel_q;
    logic [SEQ_TAG_W-1:0] tag_q;
    alu_rsp_t             rsp_q;
    logic                 rsp_valid_q;

    assign cmd_ready_o = count < CntW'(DEPTH);
    assign push        = cmd_valid_i && cmd_ready_o;
    assign fifo_empty  = (count == '0);
    assign push_req    = '{a: cmd_a_i, b: cmd_b_i, sel: cmd_sel_i, tag: cmd_tag_i};

    always_comb begin
        pop = 1'b0;
        unique case (state_q)
            StIdle:  pop = !fifo_empty;
            StResp:  pop = rsp_ready_i && !fifo_empty;
            default: pop = 1'b0;
        endcase
    end

    alu_cmd_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_req),
        .rdata_o (head),
        .count_o (count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            tag_q       <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: if (pop) state_q <= StExec;
                StExec: state_q <= StCapt;
                StCapt: begin
                    rsp_q       <= make_rsp(alu_sel_q, alu_b_q, alu_out_i, alu_carry_i, tag_q);
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= pop ? StExec : StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
            // Operands stay on the ALU inputs until the next request is issued.
            if (pop) begin
                alu_a_q   <= head.a;
                alu_b_q   <= head.b;
                alu_sel_q <= head.sel;
                tag_q     <= head.tag;
            end
        end
    end

    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign alu_sel_o    = alu_sel_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_q.data;
    assign rsp_carry_o  = rsp_q.carry;
    assign rsp_err_o    = rsp_q.err;
    assign rsp_tag_o    = rsp_q.tag;
    assign fifo_count_o = count;

endmodule
